// File: rtl/lfsr_ctrl_pkg.sv
// Shared types and default parameters for the LFSR step controller.
package lfsr_ctrl_pkg;

   typedef enum logic [1:0] {
      ModeManual = 2'd0,
      ModeAuto   = 2'd1,
      ModeBurst  = 2'd2
   } mode_e;

   typedef enum logic [1:0] {
      StManual    = 2'd0,
      StAuto      = 2'd1,
      StBurstWait = 2'd2,
      StBurstRun  = 2'd3
   } state_e;

   localparam int unsigned DivBaseDefault  = 12_000_000;
   localparam int unsigned BurstLenDefault = 16;
   localparam int unsigned CntWDefault     = 16;

endpackage

// File: rtl/lfsr_tick_gen.sv
// Prescaler for auto/burst stepping: down-counter reloaded with (DIV_BASE >> rate_sel_i) - 1.
module lfsr_tick_gen
   import lfsr_ctrl_pkg::*;
#(
   parameter int unsigned DIV_BASE = DivBaseDefault
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic       restart_i,
   input  logic [1:0] rate_sel_i,
   output logic       tick_o
);

   localparam int unsigned CntW = $clog2(DIV_BASE);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic [CntW-1:0] reload;
   logic [31:0]     period;

   // rate_sel_i is only looked at here, so a change lands at the next reload.
   always_comb begin
      period = DIV_BASE >> rate_sel_i;
      reload = CntW'(period - 32'd1);
   end

   assign tick_o = en_i & (cnt_q == '0);

   always_comb begin
      cnt_d = cnt_q;
      if (restart_i) begin
         cnt_d = reload;
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? reload : cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// Schedules single-cycle LFSR step enables in manual, auto and burst modes from debounced buttons.
module lfsr_step_ctrl
   import lfsr_ctrl_pkg::*;
#(
   parameter int unsigned DIV_BASE  = DivBaseDefault,
   parameter int unsigned BURST_LEN = BurstLenDefault,
   parameter int unsigned CNT_W     = CntWDefault
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             step_btn_i,
   input  logic             mode_btn_i,
   input  logic [1:0]       rate_sel_i,
   output logic             lfsr_en_o,
   output logic [1:0]       mode_o,
   output logic             busy_o,
   output logic [CNT_W-1:0] step_cnt_o
);

   state_e           state_q, state_d;
   logic             step_prev_q, step_prev_d, mode_prev_q, mode_prev_d;
   logic             step_edge_q, step_edge_d, mode_edge_q, mode_edge_d;
   logic [15:0]      rem_q, rem_d;
   logic             lfsr_en_q, lfsr_en_d;
   logic             busy_q, busy_d;
   logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
   logic             tick, tick_en, tick_restart;

   // Previous-level flops reset high so a button held through reset needs a release first.
   always_comb begin
      step_prev_d = step_btn_i;
      mode_prev_d = mode_btn_i;
      step_edge_d = step_btn_i & ~step_prev_q;
      mode_edge_d = mode_btn_i & ~mode_prev_q;
   end

   assign tick_en      = (state_q == StAuto) || (state_q == StBurstRun);
   assign tick_restart = (state_d != state_q) &&
                         ((state_d == StAuto) || (state_d == StBurstRun));

   lfsr_tick_gen #(
      .DIV_BASE (DIV_BASE)
   ) u_tick_gen (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .en_i       (tick_en),
      .restart_i  (tick_restart),
      .rate_sel_i (rate_sel_i),
      .tick_o     (tick)
   );

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= StManual;
         step_prev_q <= 1'b1;
         mode_prev_q <= 1'b1;
         step_edge_q <= 1'b0;
         mode_edge_q <= 1'b0;
         rem_q       <= '0;
         lfsr_en_q   <= 1'b0;
         busy_q      <= 1'b0;
         step_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         step_prev_q <= step_prev_d;
         mode_prev_q <= mode_prev_d;
         step_edge_q <= step_edge_d;
         mode_edge_q <= mode_edge_d;
         rem_q       <= rem_d;
         lfsr_en_q   <= lfsr_en_d;
         busy_q      <= busy_d;
         step_cnt_q  <= step_cnt_d;
      end
   end

   // A mode edge always wins: it masks step edges and any tick in the same cycle.
   always_comb begin
      state_d   = state_q;
      rem_d     = rem_q;
      lfsr_en_d = 1'b0;
      unique case (state_q)
         StManual: begin
            if (mode_edge_q) begin
               state_d = StAuto;
            end else if (step_edge_q) begin
               lfsr_en_d = 1'b1;
            end
         end
         StAuto: begin
            if (mode_edge_q) begin
               state_d = StBurstWait;
            end else if (tick) begin
               lfsr_en_d = 1'b1;
            end
         end
         StBurstWait: begin
            if (mode_edge_q) begin
               state_d = StManual;
            end else if (step_edge_q) begin
               rem_d   = 16'(BURST_LEN);
               state_d = StBurstRun;
            end
         end
         StBurstRun: begin
            if (mode_edge_q) begin
               rem_d   = '0;
               state_d = StManual;
            end else if (tick) begin
               lfsr_en_d = 1'b1;
               rem_d     = rem_q - 16'd1;
               if (rem_q == 16'd1) begin
                  state_d = StBurstWait;
               end
            end
         end
         default: state_d = StManual;
      endcase
      busy_d     = (state_d == StBurstRun);
      step_cnt_d = step_cnt_q + CNT_W'(lfsr_en_d);
   end

   always_comb begin
      unique case (state_q)
         StManual:                mode_o = ModeManual;
         StAuto:                  mode_o = ModeAuto;
         StBurstWait, StBurstRun: mode_o = ModeBurst;
         default:                 mode_o = ModeManual;
      endcase
      lfsr_en_o  = lfsr_en_q;
      busy_o     = busy_q;
      step_cnt_o = step_cnt_q;
   end

endmodule

// File: doc/lfsr_step_ctrl.md
# lfsr_step_ctrl

Sequencing controller that drives the Task-0 LFSR from the system clock with a single-cycle step enable, instead of clocking the LFSR from a button. It takes debounced button levels and a rate select, and schedules steps in one of three modes: manual single-step, free-running auto, or fixed-length burst. It sits between the debouncers and the LFSR on the iCEBreaker wrapper, and also exports mode and step-count status for the LEDs.

## Interface
- `DIV_BASE`, default 12_000_000: auto/burst tick period in clk_i cycles at `rate_sel_i`=0 (1 Hz at 12 MHz); must be ≥ 16.
- `BURST_LEN`, default 16: number of steps per burst, range 1..65535.
- `CNT_W`, default 16: width of the step counter.

- `clk_i`, in, 1: system clock.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `step_btn_i`, in, 1: debounced step button level, synchronous to clk_i.
- `mode_btn_i`, in, 1: debounced mode button level, synchronous to clk_i.
- `rate_sel_i`, in, 2: tick period = `DIV_BASE >> rate_sel_i`, i.e. 1x/2x/4x/8x speed.
- `lfsr_en_o`, out, 1: one-cycle step enable to the LFSR.
- `mode_o`, out, 2: current mode (`MODE_MANUAL`=0, `MODE_AUTO`=1, `MODE_BURST`=2).
- `busy_o`, out, 1: high while a burst is in progress.
- `step_cnt_o`, out, CNT_W: total steps issued since reset; wraps to 0 after all-ones.

## Operation
Edge detection:
- A rising-edge register is kept for each button.
- Each register resets to 1, so a button held through reset produces no edge until it has been released once.
- If a mode edge and a step edge occur in the same cycle, the mode edge wins and the step edge is discarded.

FSM states: MANUAL, AUTO, BURST_WAIT, BURST_RUN. `mode_o` reports BURST for both burst states.
- MANUAL
  - Step edge: one `lfsr_en_o` pulse.
  - Mode edge: go to AUTO.
- AUTO
  - One pulse per tick.
  - Step edges are ignored.
  - Mode edge: go to BURST_WAIT.
- BURST_WAIT
  - Idle.
  - Step edge: load the remaining count with BURST_LEN, go to BURST_RUN.
  - Mode edge: go to MANUAL.
- BURST_RUN
  - One pulse per tick; each pulse decrements the remaining count.
  - The pulse that takes the count to 0 returns the FSM to BURST_WAIT in the same cycle.
  - Step edges are ignored.
  - Mode edge aborts the burst: go to MANUAL with no further pulses. If a tick falls in the abort cycle, that pulse is suppressed.

Tick generator:
- Down-counter reloaded with `(DIV_BASE >> rate_sel_i) - 1`.
- A tick is issued when the counter is 0; the counter reloads on the same cycle.
- The counter is forced to reload on entry to AUTO and to BURST_RUN, so the first pulse comes one full period after entry.
- A change of `rate_sel_i` takes effect at the next reload.
- The counter is frozen in MANUAL and BURST_WAIT.

`step_cnt_o` increments by 1 in the same cycle that `lfsr_en_o` is high.

## Timing
Reset values of all outputs: `lfsr_en_o`=0, `mode_o`=MANUAL, `busy_o`=0, `step_cnt_o`=0.
- Remaining-count and tick counters also reset to 0.
- Reset mid-burst aborts the burst immediately.

Latencies:
- Manual step: if `step_btn_i` is first sampled high at edge N, `lfsr_en_o` is high for exactly the cycle after edge N+1 (one edge-register stage plus one output register).
- Mode change: `mode_o` updates one cycle after the mode edge is detected.
- `busy_o` is registered; it rises with the transition into BURST_RUN and falls with the last pulse.

Pulse rules:
- `lfsr_en_o` is never high for two consecutive cycles.
- A burst emits exactly BURST_LEN pulses, spaced exactly one tick period apart.

## Structure
- Package `lfsr_ctrl_pkg` holds:
  - `mode_e` (2-bit enum with the three mode encodings);
  - `state_e` (the four FSM states);
  - the default-parameter constants.
- Sub-module `lfsr_tick_gen` contains the prescaler: down-counter, reload, `rate_sel_i` shift and restart input.
- Edge detection, the FSM, the burst counter and the step counter live in `lfsr_step_ctrl`.

## Test plan
All scenarios use DIV_BASE=16 and BURST_LEN=4.
- Manual step: reset, then pulse `step_btn_i` 3 times (each high for 5 cycles) → exactly 3 single-cycle `lfsr_en_o` pulses, each one cycle after detection, `step_cnt_o`=3. Holding the button through reset produces 0 pulses.
- Auto rates: one mode press, `rate_sel_i`=0, run 100 cycles → pulses every 16 cycles, the first 16 cycles after entry. Switch to `rate_sel_i`=2 → period 4 cycles after the next reload.
- Burst: two mode presses (`mode_o`=2), then one step press → exactly 4 pulses 16 cycles apart, `busy_o` high from start until the last pulse, FSM back in BURST_WAIT, `step_cnt_o`=4.
- Burst abort: during a burst, after 2 pulses, press mode → no further pulses, `mode_o`=MANUAL, `busy_o`=0, `step_cnt_o`=2. Also hit the case where the mode edge coincides with a tick → that pulse is suppressed.
- Simultaneous edges: in MANUAL, raise both buttons in the same cycle → mode advances to AUTO and no manual pulse is issued.
- Async reset in AUTO: assert `rst_i` low mid-period → all outputs at reset values immediately with no clock edge required, and no pulse after release until a new edge.
- Counter wrap: run with CNT_W=4 for 17 steps → `step_cnt_o` reads 1.
